// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, FSM state encoding and direction helper
// for the snake body engine.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DEAD  = 2'd3
  } snake_state_t;

  // Up/down and left/right pairs differ only in bit 0.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    logic [1:0] o;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      DIR_RIGHT: o = DIR_LEFT;
      default:   o = DIR_LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_hit_detect.sv
// snake_hit_detect: parallel compare of one point against the segment array.
// Segments below START or at/after len never match.
module snake_hit_detect
  import snake_pkg::*;
#(
  parameter int COORD_W = 11,
  parameter int MAX_LEN = 32,
  parameter int START   = 1
) (
  input  logic [COORD_W-1:0]              px,
  input  logic [COORD_W-1:0]              py,
  input  logic [MAX_LEN-1:0][COORD_W-1:0] seg_x,
  input  logic [MAX_LEN-1:0][COORD_W-1:0] seg_y,
  input  logic [$clog2(MAX_LEN+1)-1:0]    len,
  output logic                            hit
);

  localparam int LW = $clog2(MAX_LEN + 1);

  // OR together all in-range segment matches.
  always_comb begin
    hit = 1'b0;
    for (int i = START; i < MAX_LEN; i++) begin
      if ((LW'(i) < len) && (seg_x[i] == px) && (seg_y[i] == py)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: segment register bank and move FSM for the snake game.
// Optional build macro SNAKE_WRAP_EN: walls wrap instead of killing.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int COORD_W  = 11,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int STEP     = 10,
  parameter int X_MAX    = 630,
  parameter int Y_MAX    = 470,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240
) (
  input  logic                          Snake_clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [1:0]                    dir_in,
  input  logic                          grow,
  input  logic [COORD_W-1:0]            qx,
  input  logic [COORD_W-1:0]            qy,
  output logic                          hit_head,
  output logic                          hit_body,
  output logic [COORD_W-1:0]            head_x,
  output logic [COORD_W-1:0]            head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]  len,
  output logic                          dead,
  output logic                          step_done
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic signed [COORD_W:0] STEP_S  = (COORD_W+1)'(STEP);
  localparam logic signed [COORD_W:0] X_MAX_S = (COORD_W+1)'(X_MAX);
  localparam logic signed [COORD_W:0] Y_MAX_S = (COORD_W+1)'(Y_MAX);
  localparam logic signed [COORD_W:0] ZERO_S  = '0;

  snake_state_t state, state_next;
  logic [1:0] dir;
  logic grow_pending;
  logic [MAX_LEN-1:0][COORD_W-1:0] seg_x;
  logic [MAX_LEN-1:0][COORD_W-1:0] seg_y;
  logic signed [COORD_W:0] nx, ny;
  logic wall_hit, self_hit, query_hit;
  logic latch_dir, shift_en, kill, done;

  // Tail segments beyond the initial body stack onto the last initial one.
  function automatic logic [COORD_W-1:0] init_x(input int i);
    int k;
    k = (i < INIT_LEN) ? i : INIT_LEN - 1;
    return COORD_W'(INIT_X - k * STEP);
  endfunction

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  // Head against the rest of the body, used in CHECK.
  snake_hit_detect #(.COORD_W(COORD_W), .MAX_LEN(MAX_LEN), .START(1)) u_self_hit (
    .px(seg_x[0]), .py(seg_y[0]), .seg_x(seg_x), .seg_y(seg_y), .len(len), .hit(self_hit)
  );

  // Renderer query point against the body.
  snake_hit_detect #(.COORD_W(COORD_W), .MAX_LEN(MAX_LEN), .START(1)) u_query_hit (
    .px(qx), .py(qy), .seg_x(seg_x), .seg_y(seg_y), .len(len), .hit(query_hit)
  );

  // Candidate next head in signed arithmetic, with wall handling.
  always_comb begin
    nx = $signed({1'b0, seg_x[0]});
    ny = $signed({1'b0, seg_y[0]});
    case (dir)
      DIR_UP:    ny = ny - STEP_S;
      DIR_DOWN:  ny = ny + STEP_S;
      DIR_LEFT:  nx = nx - STEP_S;
      DIR_RIGHT: nx = nx + STEP_S;
      default:   nx = nx;
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    if (nx < ZERO_S) nx = X_MAX_S;
    else if (nx > X_MAX_S) nx = ZERO_S;
    else nx = nx;
    if (ny < ZERO_S) ny = Y_MAX_S;
    else if (ny > Y_MAX_S) ny = ZERO_S;
    else ny = ny;
`else
    wall_hit = (nx < ZERO_S) || (nx > X_MAX_S) || (ny < ZERO_S) || (ny > Y_MAX_S);
`endif
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next = state;
    latch_dir  = 1'b0;
    shift_en   = 1'b0;
    kill       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_RUN: begin
        if (tick) begin
          latch_dir  = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_SHIFT: begin
        if (wall_hit) begin
          kill       = 1'b1;
          state_next = ST_DEAD;
        end else begin
          shift_en   = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (self_hit) begin
          kill       = 1'b1;
          state_next = ST_DEAD;
        end else begin
          done       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_DEAD: state_next = ST_DEAD;
      default: state_next = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Snake_clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Segment bank, direction, length, growth and status flags.
  always_ff @(posedge Snake_clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= COORD_W'(INIT_Y);
      end
      dir          <= DIR_RIGHT;
      len          <= LW'(INIT_LEN);
      grow_pending <= 1'b0;
      dead         <= 1'b0;
      step_done    <= 1'b0;
    end else begin
      step_done <= done;
      if (kill) dead <= 1'b1;
      if (latch_dir && (dir_in != opposite_dir(dir))) dir <= dir_in;
      if (shift_en) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nx[COORD_W-1:0];
        seg_y[0] <= ny[COORD_W-1:0];
        if (grow_pending && (len < LW'(MAX_LEN))) len <= len + LW'(1);
      end
      // A grow arriving during the consuming SHIFT carries to the next move.
      if (state != ST_DEAD) grow_pending <= shift_en ? grow : (grow_pending | grow);
    end
  end

  // Registered query results.
  always_ff @(posedge Snake_clk) begin
    if (rst) begin
      hit_head <= 1'b0;
      hit_body <= 1'b0;
    end else begin
      hit_head <= (qx == seg_x[0]) && (qy == seg_y[0]);
      hit_body <= query_hit;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed self-checking bench for snake_body_engine.
module tb_snake_body_engine;

  logic Snake_clk = 1'b0;
  always #5 Snake_clk = ~Snake_clk;

  logic rst, tick, grow;
  logic [1:0] dir_in;
  logic [10:0] qx, qy;
  logic hit_head, hit_body, dead, step_done;
  logic [10:0] head_x, head_y;
  logic [5:0] len;
  logic s_hit_head, s_hit_body, s_dead, s_step_done;
  logic [10:0] s_head_x, s_head_y;
  logic [2:0] s_len;

  int total = 0;
  int bad = 0;

  snake_body_engine dut (
    .Snake_clk(Snake_clk), .rst(rst), .tick(tick), .dir_in(dir_in), .grow(grow),
    .qx(qx), .qy(qy), .hit_head(hit_head), .hit_body(hit_body),
    .head_x(head_x), .head_y(head_y), .len(len), .dead(dead), .step_done(step_done)
  );

  snake_body_engine #(.MAX_LEN(4)) dut_small (
    .Snake_clk(Snake_clk), .rst(rst), .tick(tick), .dir_in(dir_in), .grow(grow),
    .qx(qx), .qy(qy), .hit_head(s_hit_head), .hit_body(s_hit_body),
    .head_x(s_head_x), .head_y(s_head_y), .len(s_len), .dead(s_dead), .step_done(s_step_done)
  );

  task do_reset();
    @(negedge Snake_clk);
    rst = 1'b1; tick = 1'b0; grow = 1'b0;
    @(posedge Snake_clk);
    @(posedge Snake_clk);
    #1 rst = 1'b0;
  endtask

  // Issue one tick and return the number of edges until step_done or dead.
  task move(input logic [1:0] d, output int lat);
    @(negedge Snake_clk);
    dir_in = d; tick = 1'b1;
    @(posedge Snake_clk);
    #1 tick = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Snake_clk);
      #1;
      if (step_done || dead) begin
        lat = k;
        break;
      end
    end
  endtask

  task test_reset();
    do_reset();
    total++; if (head_x !== 11'd320) begin bad++; $display("FAIL reset_head_x got=%0d want=320", head_x); end
    total++; if (head_y !== 11'd240) begin bad++; $display("FAIL reset_head_y got=%0d want=240", head_y); end
    total++; if (len !== 6'd4) begin bad++; $display("FAIL reset_len got=%0d want=4", len); end
    total++; if (dead !== 1'b0 || step_done !== 1'b0) begin bad++; $display("FAIL reset_flags got dead=%0b step_done=%0b want 0 0", dead, step_done); end
    total++; if (hit_head !== 1'b0 || hit_body !== 1'b0) begin bad++; $display("FAIL reset_hits got=%0b%0b want=00", hit_head, hit_body); end
  endtask

  task test_move();
    int lat;
    logic [10:0] want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      move(2'd3, lat);
      want = 11'(330 + 10 * i);
      total++; if (head_x !== want) begin bad++; $display("FAIL move_head_x got=%0d want=%0d", head_x, want); end
      total++; if (lat !== 2) begin bad++; $display("FAIL move_latency got=%0d want=2", lat); end
      @(posedge Snake_clk); #1;
      total++; if (step_done !== 1'b0) begin bad++; $display("FAIL move_pulse_width got=%0b want=0", step_done); end
    end
    total++; if (len !== 6'd4 || head_y !== 11'd240) begin bad++; $display("FAIL move_len_y got len=%0d y=%0d want 4 240", len, head_y); end
    // (310,240) now sits at index 4, outside len 4.
    @(negedge Snake_clk); qx = 11'd310; qy = 11'd240;
    @(posedge Snake_clk); #1;
    total++; if (hit_body !== 1'b0) begin bad++; $display("FAIL query_len_mask got=%0b want=0", hit_body); end
  endtask

  task test_reversal();
    int lat;
    do_reset();
    move(2'd2, lat);
    total++; if (head_x !== 11'd330 || lat !== 2) begin bad++; $display("FAIL reversal got x=%0d lat=%0d want 330 2", head_x, lat); end
  endtask

  task test_grow();
    int lat;
    do_reset();
    @(negedge Snake_clk); grow = 1'b1;
    @(posedge Snake_clk); #1 grow = 1'b0;
    move(2'd3, lat);
    total++; if (len !== 6'd5) begin bad++; $display("FAIL grow_len1 got=%0d want=5", len); end
    total++; if (s_len !== 3'd4) begin bad++; $display("FAIL grow_at_max got=%0d want=4", s_len); end
    move(2'd3, lat);
    total++; if (len !== 6'd5) begin bad++; $display("FAIL grow_len2 got=%0d want=5", len); end
  endtask

  task test_wall();
    int lat;
    do_reset();
    for (int i = 0; i < 31; i++) move(2'd3, lat);
    total++; if (head_x !== 11'd630 || dead !== 1'b0) begin bad++; $display("FAIL wall_approach got x=%0d dead=%0b want 630 0", head_x, dead); end
    move(2'd3, lat);
`ifdef SNAKE_WRAP_EN
    total++; if (head_x !== 11'd0 || dead !== 1'b0) begin bad++; $display("FAIL wall_wrap got x=%0d dead=%0b want 0 0", head_x, dead); end
`else
    total++; if (head_x !== 11'd630 || dead !== 1'b1) begin bad++; $display("FAIL wall_kill got x=%0d dead=%0b want 630 1", head_x, dead); end
`endif
  endtask

  task test_self_collision();
    int lat;
    do_reset();
    @(negedge Snake_clk); grow = 1'b1;
    @(posedge Snake_clk); #1 grow = 1'b0;
    move(2'd3, lat);
    move(2'd0, lat);
    move(2'd2, lat);
    total++; if (dead !== 1'b0 || head_x !== 11'd320 || head_y !== 11'd230) begin bad++; $display("FAIL self_pre got x=%0d y=%0d dead=%0b want 320 230 0", head_x, head_y, dead); end
    move(2'd1, lat);
    total++; if (dead !== 1'b1 || lat !== 2) begin bad++; $display("FAIL self_dead got dead=%0b lat=%0d want 1 2", dead, lat); end
    move(2'd3, lat);
    total++; if (head_x !== 11'd320 || head_y !== 11'd240 || len !== 6'd5) begin bad++; $display("FAIL dead_frozen got x=%0d y=%0d len=%0d want 320 240 5", head_x, head_y, len); end
  endtask

  task test_reset_mid_move();
    do_reset();
    @(negedge Snake_clk); dir_in = 2'd3; tick = 1'b1;
    @(posedge Snake_clk);
    #1 tick = 1'b0; rst = 1'b1;
    @(posedge Snake_clk);
    #1 rst = 1'b0;
    @(posedge Snake_clk); @(posedge Snake_clk); #1;
    total++; if (head_x !== 11'd320 || step_done !== 1'b0) begin bad++; $display("FAIL reset_mid got x=%0d step_done=%0b want 320 0", head_x, step_done); end
  endtask

  task test_query();
    do_reset();
    @(negedge Snake_clk); qx = 11'd300; qy = 11'd240;
    @(posedge Snake_clk); #1;
    total++; if (hit_body !== 1'b1 || hit_head !== 1'b0) begin bad++; $display("FAIL query_body got=%0b%0b want head=0 body=1", hit_head, hit_body); end
    @(negedge Snake_clk); qx = 11'd350;
    @(posedge Snake_clk); #1;
    total++; if (hit_body !== 1'b0 || hit_head !== 1'b0) begin bad++; $display("FAIL query_none got=%0b%0b want 00", hit_head, hit_body); end
    @(negedge Snake_clk); qx = 11'd320;
    @(posedge Snake_clk); #1;
    total++; if (hit_head !== 1'b1 || hit_body !== 1'b0) begin bad++; $display("FAIL query_head got=%0b%0b want head=1 body=0", hit_head, hit_body); end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; grow = 1'b0; dir_in = 2'd3; qx = 11'd0; qy = 11'd0;
    test_reset();
    test_move();
    test_reversal();
    test_grow();
    test_wall();
    test_self_collision();
    test_reset_mid_move();
    test_query();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
